// File: rtl/multi_reg_sequencer.sv
// Multi-register load/store sequencer (PUSH/POP, LDM/STM) driving a single
// memory port and the register-file write port, with optional base writeback.
module multi_reg_sequencer #(
    parameter int unsigned STEP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_load,
    input  logic [7:0]  reg_list,
    input  logic        extra,
    input  logic [3:0]  base_sel,
    input  logic        writeback,
    input  logic [31:0] base_value,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        busy,
    output logic        done,
    output logic        pc_hold,
    output logic [3:0]  regA_select,
    output logic [3:0]  regB_select,
    output logic [3:0]  write_dest,
    output logic        write_en,
    output logic [31:0] write_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata
);

    localparam int unsigned LIST_W = 9;
    localparam logic [31:0] STEP_W = 32'(STEP);
    localparam logic [3:0]  NO_REG = 4'hF;
    // The ninth list entry is LR on a store and PC on a load; both share code 1001.
    localparam logic [3:0]  EXTRA_CODE = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_WB,
        S_DONE
    } state_t;

    state_t              r_state;
    logic                r_is_load;
    logic [LIST_W-1:0]   r_list;
    logic [3:0]          r_base_sel;
    logic                r_writeback;
    logic                r_wb_skip;
    logic [31:0]         r_addr;
    logic [31:0]         r_wb_value;

    logic [31:0]         w_span;
    logic [LIST_W-1:0]   w_cur_onehot;
    logic [LIST_W-1:0]   w_list_next;
    logic [3:0]          w_cur_idx;
    logic [3:0]          w_cur_code;
    logic                w_xfer;
    logic                w_load_wr;
    logic                w_wb_wr;

    // Total byte span of the transfer block: STEP * popcount(list), modulo 2^32.
    assign w_span       = STEP_W * 32'($countones(r_list));
    // Lowest pending register is always the next one on the bus.
    assign w_cur_onehot = r_list & (~r_list + 9'd1);
    assign w_list_next  = r_list & ~w_cur_onehot;

    // Index of the lowest pending list bit.
    always_comb begin
        w_cur_idx = 4'd0;
        for (int i = LIST_W - 1; i >= 0; i--) begin
            if (r_list[i]) begin
                w_cur_idx = 4'(i);
            end
        end
    end

    assign w_cur_code = (w_cur_idx == 4'd8) ? EXTRA_CODE : w_cur_idx;

    // Sequencer state and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_is_load   <= 1'b0;
            r_list      <= '0;
            r_base_sel  <= NO_REG;
            r_writeback <= 1'b0;
            r_wb_skip   <= 1'b0;
            r_addr      <= '0;
            r_wb_value  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_is_load   <= is_load;
                        r_list      <= {extra, reg_list};
                        r_base_sel  <= base_sel;
                        r_writeback <= writeback;
                        // A load that overwrites its own base keeps the loaded value.
                        r_wb_skip   <= is_load && !base_sel[3] && reg_list[base_sel[2:0]];
                        r_state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_addr     <= r_is_load ? base_value : (base_value - w_span);
                    r_wb_value <= r_is_load ? (base_value + w_span) : (base_value - w_span);
                    r_state    <= (r_list == '0) ? S_DONE : S_XFER;
                end
                S_XFER: begin
                    if (mem_ready) begin
                        r_list <= w_list_next;
                        r_addr <= r_addr + STEP_W;
                        if (w_list_next == '0) begin
                            r_state <= r_writeback ? S_WB : S_DONE;
                        end
                    end
                end
                S_WB: begin
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign w_xfer    = (r_state == S_XFER);
    assign w_load_wr = w_xfer && r_is_load && mem_ready;
    assign w_wb_wr   = (r_state == S_WB) && !r_wb_skip;

    // Output decode from the state register; all fall to reset values with the state.
    assign busy        = (r_state != S_IDLE);
    assign pc_hold     = busy;
    assign done        = (r_state == S_DONE);
    assign regA_select = busy ? r_base_sel : NO_REG;
    assign regB_select = (w_xfer && !r_is_load) ? w_cur_code : NO_REG;

    assign mem_req   = w_xfer;
    assign mem_we    = w_xfer && !r_is_load;
    assign mem_addr  = w_xfer ? r_addr : 32'd0;
    assign mem_wdata = (w_xfer && !r_is_load) ? store_data : 32'd0;

    assign write_en   = w_load_wr || w_wb_wr;
    assign write_dest = w_load_wr ? w_cur_code : (w_wb_wr ? r_base_sel : NO_REG);
    assign write_in   = w_load_wr ? mem_rdata : (w_wb_wr ? r_wb_value : 32'd0);

endmodule

// File: tb/tb_multi_reg_sequencer.sv
// Randomized scoreboard bench for multi_reg_sequencer with a transaction-level model.
module tb_multi_reg_sequencer;

    localparam int unsigned STEP = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_load;
    logic [7:0]  reg_list;
    logic        extra;
    logic [3:0]  base_sel;
    logic        writeback;
    logic [31:0] base_value;
    logic [31:0] store_data;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        busy;
    logic        done;
    logic        pc_hold;
    logic [3:0]  regA_select;
    logic [3:0]  regB_select;
    logic [3:0]  write_dest;
    logic        write_en;
    logic [31:0] write_in;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    multi_reg_sequencer #(.STEP(STEP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_load(is_load),
        .reg_list(reg_list), .extra(extra), .base_sel(base_sel),
        .writeback(writeback), .base_value(base_value), .store_data(store_data),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy), .done(done),
        .pc_hold(pc_hold), .regA_select(regA_select), .regB_select(regB_select),
        .write_dest(write_dest), .write_en(write_en), .write_in(write_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
    );

    always #5 clk = ~clk;

    // Register file indexed by register code (0-7 Rn, 8 SP, 9 LR/PC).
    logic [31:0] rf [16];
    assign base_value = rf[regA_select];
    assign store_data = rf[regB_select];

    // Memory read model: address hash plus a few directed overrides.
    logic        ovr_v [4];
    logic [31:0] ovr_a [4];
    logic [31:0] ovr_d [4];

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        logic [31:0] v;
        v = {a[15:0] ^ 16'h9E37, a[31:16] + 16'h1234};
        for (int k = 0; k < 4; k++) if (ovr_v[k] && ovr_a[k] == a) v = ovr_d[k];
        return v;
    endfunction

    always_comb begin
        mem_rdata = {mem_addr[15:0] ^ 16'h9E37, mem_addr[31:16] + 16'h1234};
        for (int k = 0; k < 4; k++) if (ovr_v[k] && ovr_a[k] == mem_addr) mem_rdata = ovr_d[k];
    end

    typedef struct {
        int          kind;   // 0 memory transfer, 1 register write, 2 done
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  c;
    } ev_t;

    ev_t sbq[$];
    int  checks = 0;
    int  errors = 0;
    int  rdy_mode = 1;      // 0 random, 1 always ready, 2 fixed stall budget
    int  stall_budget = 0;
    int  stall_cnt = 0;
    logic [3:0] cur_bs = 4'hF;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset();
        chk("reset_ctrl", {busy, done, pc_hold, write_en, mem_req, mem_we,
                           write_dest, regA_select, regB_select},
            {6'b0, 4'hF, 4'hF, 4'hF});
        chk("reset_data", {mem_addr, mem_wdata, write_in}, 96'd0);
    endtask

    task automatic expect_ev(input int kind, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] c);
        ev_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected kind=%0d a=%0h b=%0h actual event required none",
                     kind, a, b);
        end else begin
            e = sbq.pop_front();
            chk("ev_kind", 64'(kind), 64'(e.kind));
            if (kind == e.kind) begin
                if (kind == 0) begin
                    chk("mem_addr", 64'(a), 64'(e.a));
                    chk("mem_we", 64'(c), 64'(e.c));
                    if (e.c == 4'd1) chk("mem_wdata", 64'(b), 64'(e.b));
                end else if (kind == 1) begin
                    chk("write_dest", 64'(c), 64'(e.c));
                    chk("write_in", 64'(b), 64'(e.b));
                end
            end
        end
    endtask

    // Memory ready generator; counts the stall cycles it inserts.
    initial begin
        mem_ready = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            case (rdy_mode)
                0:       mem_ready = ($urandom_range(0, 3) != 0);
                2:       mem_ready = !(mem_req && stall_budget > 0);
                default: mem_ready = 1'b1;
            endcase
            if (mem_req && !mem_ready) begin
                stall_cnt++;
                if (stall_budget > 0) stall_budget--;
            end
        end
    end

    // Monitor: pops expected events whenever the DUT presents a transfer, write or done.
    initial begin
        logic        prev_stall;
        logic [31:0] prev_addr, prev_wdata;
        prev_stall = 1'b0;
        prev_addr  = '0;
        prev_wdata = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (prev_stall && mem_req) begin
                    chk("stall_addr", 64'(mem_addr), 64'(prev_addr));
                    chk("stall_wdata", 64'(mem_wdata), 64'(prev_wdata));
                end
                if (mem_req && mem_ready) expect_ev(0, mem_addr, mem_wdata, {3'b0, mem_we});
                if (write_en) expect_ev(1, 32'd0, write_in, write_dest);
                else chk("idle_dest", 64'(write_dest), 64'hF);
                if (done) expect_ev(2, 32'd0, 32'd0, 4'd0);
                chk("pc_hold", 64'(pc_hold), 64'(busy));
                chk("regA_sel", 64'(regA_select), busy ? 64'(cur_bs) : 64'hF);
                prev_stall = mem_req && !mem_ready;
                prev_addr  = mem_addr;
                prev_wdata = mem_wdata;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // Issue one operation: build expected events from the architectural rules, run, check.
    task automatic run_op(input logic ld, input logic [7:0] lst, input logic ex,
                          input logic [3:0] bs, input logic wb, input int mode,
                          input int stalls);
        logic [31:0] loc [16];
        logic [8:0]  l9;
        logic [31:0] base, addr, span, d;
        logic [3:0]  code;
        int          n, wbeff, cyc, mreq;
        logic        got, skip;
        for (int k = 0; k < 16; k++) loc[k] = rf[k];
        l9   = {ex, lst};
        base = rf[bs];
        n    = 0;
        for (int k = 0; k < 9; k++) if (l9[k]) n++;
        span = 32'(STEP) * 32'(n);
        addr = ld ? base : base - span;
        for (int k = 0; k < 9; k++) begin
            if (l9[k]) begin
                code = (k == 8) ? 4'd9 : 4'(k);
                if (ld) begin
                    d = mem_val(addr);
                    sbq.push_back('{0, addr, 32'd0, 4'd0});
                    sbq.push_back('{1, 32'd0, d, code});
                    loc[code] = d;
                end else begin
                    sbq.push_back('{0, addr, rf[code], 4'd1});
                end
                addr = addr + 32'(STEP);
            end
        end
        skip  = ld && (bs < 4'd8) && lst[bs[2:0]];
        wbeff = (wb && n != 0) ? 1 : 0;
        if (wbeff == 1 && !skip) begin
            d = ld ? base + span : base - span;
            sbq.push_back('{1, 32'd0, d, bs});
            loc[bs] = d;
        end
        sbq.push_back('{2, 32'd0, 32'd0, 4'd0});

        @(negedge clk);
        #3;
        rdy_mode = mode; stall_budget = stalls; stall_cnt = 0; cur_bs = bs;
        is_load = ld; reg_list = lst; extra = ex; base_sel = bs; writeback = wb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        is_load = 1'($urandom); reg_list = 8'($urandom); extra = 1'($urandom);
        base_sel = 4'($urandom); writeback = 1'($urandom);
        cyc = 0; mreq = 0; got = 1'b0;
        while (!got && cyc < 300) begin
            @(negedge clk);
            #3;
            cyc++;
            if (mem_req) mreq++;
            if (done) got = 1'b1;
            if (cyc == 1) start = 1'($urandom);
        end
        start = 1'b0;
        chk("done_seen", 64'(got), 64'd1);
        chk("latency", 64'(cyc), 64'(2 + n + wbeff + stall_cnt));
        chk("mreq_cycles", 64'(mreq), 64'(n + stall_cnt));
        chk("sb_drained", 64'(sbq.size()), 64'd0);
        sbq.delete();
        for (int k = 0; k < 16; k++) rf[k] = loc[k];
        @(negedge clk);
        #3;
        chk("idle_after", 64'(busy), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; is_load = 1'b0; reg_list = '0; extra = 1'b0;
        base_sel = '0; writeback = 1'b0;
        for (int k = 0; k < 16; k++) rf[k] = $urandom;
        for (int k = 0; k < 4; k++) begin
            ovr_v[k] = 1'b0; ovr_a[k] = '0; ovr_d[k] = '0;
        end
        #1;
        chk_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // PUSH {R0,R2,LR}, SP=0x100, writeback
        rf[8] = 32'h100;
        run_op(1'b0, 8'b0000_0101, 1'b1, 4'd8, 1'b1, 1, 0);
        chk("push_sp", 64'(rf[8]), 64'hF4);

        // POP {R1,PC}, SP=0xF0
        rf[8] = 32'hF0;
        ovr_v[0] = 1'b1; ovr_a[0] = 32'hF0; ovr_d[0] = 32'h11;
        ovr_v[1] = 1'b1; ovr_a[1] = 32'hF4; ovr_d[1] = 32'h200;
        run_op(1'b1, 8'b0000_0010, 1'b1, 4'd8, 1'b1, 1, 0);
        ovr_v[0] = 1'b0; ovr_v[1] = 1'b0;

        // Empty list, writeback requested but nothing to do
        run_op(1'b0, 8'h00, 1'b0, 4'd2, 1'b1, 1, 0);

        // Store {R5} with three stall cycles
        run_op(1'b0, 8'b0010_0000, 1'b0, 4'd1, 1'b0, 2, 3);

        // LDM R3!,{R3,R4}
        rf[3] = 32'h40;
        run_op(1'b1, 8'b0001_1000, 1'b0, 4'd3, 1'b1, 1, 0);

        // Address wrap both directions
        rf[8] = 32'h8;
        run_op(1'b0, 8'b0000_0111, 1'b1, 4'd8, 1'b1, 1, 0);
        rf[6] = 32'hFFFF_FFF8;
        run_op(1'b1, 8'b0000_0111, 1'b0, 4'd6, 1'b1, 0, 0);

        // Reset during the second of three stores: only two transfers may appear
        rf[8] = 32'h2000;
        sbq.push_back('{0, 32'h2000 - 32'd12, rf[0], 4'd1});
        sbq.push_back('{0, 32'h2000 - 32'd8, rf[1], 4'd1});
        @(negedge clk);
        #3;
        rdy_mode = 1; cur_bs = 4'd8;
        is_load = 1'b0; reg_list = 8'b0000_0011; extra = 1'b1; base_sel = 4'd8;
        writeback = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #3;
        end
        rst_n = 1'b0;
        #1;
        chk_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset();
        chk("abort_sb", 64'(sbq.size()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        #3;
        chk("abort_quiet", 64'(busy), 64'd0);
        sbq.delete();

        // Randomized operations
        for (int t = 0; t < 60; t++) begin
            run_op(1'($urandom), 8'($urandom), 1'($urandom), 4'($urandom_range(0, 8)),
                   1'($urandom), $urandom_range(0, 1), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
